// File: rtl/sdram_cp_feeder_pkg.sv
// Shared constants and drain-state encoding for the SDRAM page-copy feeder.
package sdram_cp_pkg;
  localparam int CP_WORDS = 512;
  localparam int CP_LEAD  = 2;
  localparam int CP_IDX_W = $clog2(CP_WORDS);

  typedef enum logic [1:0] {
    D_IDLE,
    D_REQ,
    D_XFER
  } drain_state_t;
endpackage

// File: rtl/sdram_cp_feeder_if.sv
// SDRAM controller page-copy port; master is the data source, slave is the controller.
interface sdram_cp_if;
  logic        cpsel;
  logic [25:0] cpaddr;
  logic [15:0] cpdin;
  logic        cpreq;
  logic        cprd;
  logic        cpbusy;

  modport master (
    output cpsel, cpaddr, cpdin, cpreq,
    input  cprd, cpbusy
  );

  modport slave (
    input  cpsel, cpaddr, cpdin, cpreq,
    output cprd, cpbusy
  );
endinterface

// File: rtl/sdram_cp_feeder_dpram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register only updates on i_re, so it holds its word while reads are paused.
module cp_dpram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sdram_cp_feeder.sv
// Ping-pong page-copy source: fills two 512-word banks from the loader stream and
// replays each full bank to the controller copy port, one word per en-qualified cprd cycle.
module sdram_cp_feeder
  import sdram_cp_pkg::*;
#(
  parameter logic [15:0] PAD_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        start,
  input  logic [25:0] base_addr,
  input  logic        in_wr,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        idle,
  sdram_cp_if.master  cp
);

  logic                r_fill_bank, r_drain_bank, r_padding;
  logic [CP_IDX_W-1:0] r_cnt, r_rd_ptr;
  logic [1:0]          r_full;
  logic [25:0]         r_bank_addr [2];
  logic [25:0]         r_next_addr, r_cpaddr;
  drain_state_t        r_state, w_state_nxt;

  logic                w_wr, w_last, w_launch, w_drain_done, w_cpreq, w_cpsel, w_rd_en;
  logic [CP_IDX_W-1:0] w_cnt_nxt;
  logic [15:0]         w_wdata, w_cpdin;
  logic [1:0]          w_full_set, w_full_clr;

  assign in_ready   = ~r_full[r_fill_bank] & ~r_padding;
  assign idle       = ~|r_full & (r_state == D_IDLE) & ~r_padding;
  // Padding owns the write port; a word arriving with flush lands before the pad run.
  assign w_wr       = r_padding | (in_wr & in_ready);
  assign w_wdata    = r_padding ? PAD_VALUE : in_data;
  assign w_last     = w_wr & (r_cnt == CP_IDX_W'(CP_WORDS - 1));
  assign w_cnt_nxt  = w_wr ? r_cnt + CP_IDX_W'(1) : r_cnt;
  assign w_full_set = w_last ? (2'b01 << r_fill_bank) : 2'b00;
  assign w_full_clr = w_drain_done ? (2'b01 << r_drain_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_bank    <= 1'b0;
      r_padding      <= 1'b0;
      r_cnt          <= '0;
      r_full         <= '0;
      r_next_addr    <= '0;
      r_bank_addr[0] <= '0;
      r_bank_addr[1] <= '0;
    end else begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
      r_cnt  <= w_cnt_nxt;
      if (w_last) begin
        r_bank_addr[r_fill_bank] <= r_next_addr;
        r_next_addr              <= r_next_addr + 26'(CP_WORDS);
        r_fill_bank              <= ~r_fill_bank;
        r_padding                <= 1'b0;
      end else if (flush && !r_padding && w_cnt_nxt != '0) begin
        r_padding <= 1'b1;
      end
      if (start && idle) begin
        r_next_addr <= base_addr;
        r_cnt       <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= D_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_drain_done = 1'b0;
    w_cpreq      = 1'b0;
    w_cpsel      = 1'b0;
    case (r_state)
      D_IDLE: begin
        if (r_full[r_drain_bank]) begin
          w_launch    = 1'b1;
          w_state_nxt = D_REQ;
        end
      end
      D_REQ: begin
        w_cpreq = 1'b1;
        w_cpsel = 1'b1;
        if (cp.cpbusy) w_state_nxt = D_XFER;
      end
      D_XFER: begin
        w_cpsel = 1'b1;
        if (!cp.cpbusy) begin
          w_drain_done = 1'b1;
          w_state_nxt  = D_IDLE;
        end
      end
      default: w_state_nxt = D_IDLE;
    endcase
  end

  // Read runs one en-cycle ahead of cpdin: the fetch issued at cprd cycle j shows at cycle j+1.
  assign w_rd_en = en & cp.cprd & w_cpsel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drain_bank <= 1'b0;
      r_cpaddr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (w_launch) begin
        r_cpaddr <= r_bank_addr[r_drain_bank];
        r_rd_ptr <= '0;
      end else if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + CP_IDX_W'(1);
      end
      if (w_drain_done) r_drain_bank <= ~r_drain_bank;
    end
  end

  cp_dpram #(
    .AW(CP_IDX_W + 1),
    .DW(16)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_wr),
    .i_waddr({r_fill_bank, r_cnt}),
    .i_wdata(w_wdata),
    .i_re   (w_rd_en),
    .i_raddr({r_drain_bank, r_rd_ptr}),
    .o_rdata(w_cpdin)
  );

  assign cp.cpsel  = w_cpsel;
  assign cp.cpreq  = w_cpreq;
  assign cp.cpaddr = r_cpaddr;
  assign cp.cpdin  = w_cpdin;
endmodule

// File: tb/tb_sdram_cp_feeder.sv
// Directed bench for sdram_cp_feeder with a behavioural copy-port controller.
module tb_sdram_cp_feeder;
  import sdram_cp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, start, in_wr, flush, in_ready, idle;
  logic [25:0] base_addr;
  logic [15:0] in_data;

  sdram_cp_if cp();

  sdram_cp_feeder #(.PAD_VALUE(16'h0000)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .base_addr(base_addr),
    .in_wr(in_wr), .in_data(in_data), .in_ready(in_ready), .flush(flush),
    .idle(idle), .cp(cp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int busy_delay = 2;
  bit en_mode    = 1'b0;
  bit ctl_enable = 1'b1;
  int txn_done = 0, req_count = 0, hold_bad = 0, drop_bad = 0, dup_req = 0;
  int dout_hold_err = 0, en_low_cycles = 0, last_req_hi = 0;
  logic [15:0] cap_q[$];
  logic [25:0] addr_q[$];

  // Controller model: answers each cpreq with cpbusy, then 513 en-qualified cprd cycles.
  initial begin : ctl_model
    int hi, j;
    logic [15:0] prev;
    bit prev_en_low;
    cp.cprd = 1'b0; cp.cpbusy = 1'b0; en = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ctl_enable && reset === 1'b0 && cp.cpreq === 1'b1) begin
        req_count++;
        addr_q.push_back(cp.cpaddr);
        hi = 1;
        for (int k = 0; k < busy_delay; k++) begin
          @(posedge clk); #1;
          if (cp.cpreq !== 1'b1) hold_bad++; else hi++;
        end
        last_req_hi = hi;
        cp.cpbusy = 1'b1;
        @(posedge clk); #1;
        if (cp.cpreq !== 1'b0) drop_bad++;
        repeat (2) begin
          @(posedge clk); #1;
          if (cp.cpreq !== 1'b0) dup_req++;
        end
        cp.cprd = 1'b1; j = 0; prev_en_low = 1'b0; prev = cp.cpdin;
        while (j < CP_WORDS + 1) begin
          if (prev_en_low && cp.cpdin !== prev) dout_hold_err++;
          en = en_mode ? ~en : 1'b1;
          if (en) begin
            j++;
            if (j >= CP_LEAD) cap_q.push_back(cp.cpdin);
          end else begin
            en_low_cycles++;
          end
          prev_en_low = !en;
          prev = cp.cpdin;
          @(posedge clk); #1;
          if (cp.cpreq !== 1'b0) dup_req++;
        end
        cp.cprd = 1'b0; en = 1'b1;
        repeat (2) begin
          @(posedge clk); #1;
          if (cp.cpreq !== 1'b0) dup_req++;
        end
        cp.cpbusy = 1'b0;
        @(posedge clk); #1;
        txn_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [25:0] a);
    base_addr = a; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_txns(input int target, output bit ok);
    int cyc = 0;
    while (txn_done < target && cyc < 6000) begin
      tick();
      cyc++;
    end
    ok = (txn_done >= target);
  endtask

  task automatic send_words(input int n, input logic [15:0] base, input int done0,
                            output int stalls, output int bad_stalls);
    int sent = 0;
    int cyc = 0;
    logic acc;
    stalls = 0; bad_stalls = 0;
    while (sent < n && cyc < 8 * n + 4000) begin
      in_wr = 1'b1; in_data = base + 16'(sent); acc = in_ready;
      if (!acc) begin
        stalls++;
        if ((sent / CP_WORDS) - (txn_done - done0) < 2) bad_stalls++;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_wr = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else n_pass++;
    n_checks++; if (cp.cpsel !== 1'b0) $display("FAIL rst_cpsel: got %b want 0", cp.cpsel); else n_pass++;
    n_checks++; if (cp.cpreq !== 1'b0) $display("FAIL rst_cpreq: got %b want 0", cp.cpreq); else n_pass++;
    n_checks++; if (cp.cpaddr !== 26'h0) $display("FAIL rst_cpaddr: got %h want 0", cp.cpaddr); else n_pass++;
    n_checks++; if (cp.cpdin !== 16'h0) $display("FAIL rst_cpdin: got %h want 0", cp.cpdin); else n_pass++;
  endtask

  task automatic test_single();
    int d0, r0, c0, a0, st, bst, errs;
    logic [25:0] got;
    bit ok;
    d0 = txn_done; r0 = req_count; c0 = cap_q.size(); a0 = addr_q.size();
    pulse_start(26'h0040000);
    send_words(512, 16'h1000, d0, st, bst);
    wait_txns(d0 + 1, ok);
    tick();
    n_checks++; if (!ok) $display("FAIL single_wait: got %0d transfers want 1", txn_done - d0); else n_pass++;
    n_checks++; if (req_count - r0 != 1) $display("FAIL single_reqs: got %0d want 1", req_count - r0); else n_pass++;
    got = (addr_q.size() > a0) ? addr_q[a0] : 'x;
    n_checks++; if (got !== 26'h0040000) $display("FAIL single_addr: got %h want 0040000", got); else n_pass++;
    errs = 0;
    for (int k = 0; k < 512; k++) begin
      logic [15:0] want;
      want = 16'h1000 + 16'(k);
      if (c0 + k >= cap_q.size() || cap_q[c0 + k] !== want) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL single_data: got %0d bad words want 0", errs); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL single_idle: got %b want 1", idle); else n_pass++;
    // Flush with an empty bank must not start padding or a transfer.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (idle !== 1'b1) $display("FAIL flush_empty_idle: got %b want 1", idle); else n_pass++;
    repeat (10) tick();
    n_checks++; if (req_count - r0 != 1) $display("FAIL flush_empty_req: got %0d want 1", req_count - r0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, c0, a0, st, bst, errs;
    logic [25:0] got, want_a;
    bit ok;
    d0 = txn_done; c0 = cap_q.size(); a0 = addr_q.size();
    pulse_start(26'h0040000);
    send_words(1536, 16'h2000, d0, st, bst);
    wait_txns(d0 + 3, ok);
    n_checks++; if (!ok) $display("FAIL b2b_wait: got %0d transfers want 3", txn_done - d0); else n_pass++;
    n_checks++; if (st == 0) $display("FAIL b2b_stall: got %0d stall cycles want >0", st); else n_pass++;
    n_checks++; if (bst != 0) $display("FAIL b2b_early_stall: got %0d want 0", bst); else n_pass++;
    for (int t = 0; t < 3; t++) begin
      want_a = 26'h0040000 + 26'(t * 512);
      got = (addr_q.size() > a0 + t) ? addr_q[a0 + t] : 'x;
      n_checks++; if (got !== want_a) $display("FAIL b2b_addr%0d: got %h want %h", t, got, want_a); else n_pass++;
    end
    n_checks++; if (cap_q.size() - c0 != 1536) $display("FAIL b2b_count: got %0d want 1536", cap_q.size() - c0); else n_pass++;
    errs = 0;
    for (int k = 0; k < 1536; k++) begin
      logic [15:0] want;
      want = 16'h2000 + 16'(k);
      if (c0 + k >= cap_q.size() || cap_q[c0 + k] !== want) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL b2b_data: got %0d bad words want 0", errs); else n_pass++;
  endtask

  task automatic test_flush();
    int d0, c0, a0, st, bst, errs, perrs;
    logic [25:0] got;
    bit ok;
    d0 = txn_done; c0 = cap_q.size(); a0 = addr_q.size();
    pulse_start(26'h0100000);
    send_words(99, 16'hA000, d0, st, bst);
    in_wr = 1'b1; in_data = 16'hA000 + 16'd99; flush = 1'b1;
    tick();
    in_wr = 1'b0; flush = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_pad_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL flush_pad_idle: got %b want 0", idle); else n_pass++;
    wait_txns(d0 + 1, ok);
    tick();
    n_checks++; if (!ok) $display("FAIL flush_wait: got %0d transfers want 1", txn_done - d0); else n_pass++;
    got = (addr_q.size() > a0) ? addr_q[a0] : 'x;
    n_checks++; if (got !== 26'h0100000) $display("FAIL flush_addr: got %h want 0100000", got); else n_pass++;
    errs = 0; perrs = 0;
    for (int k = 0; k < 512; k++) begin
      logic [15:0] want;
      want = (k < 100) ? 16'hA000 + 16'(k) : 16'h0000;
      if (c0 + k >= cap_q.size() || cap_q[c0 + k] !== want) begin
        if (k < 100) errs++; else perrs++;
      end
    end
    n_checks++; if (errs != 0) $display("FAIL flush_data: got %0d bad words want 0", errs); else n_pass++;
    n_checks++; if (perrs != 0) $display("FAIL flush_pad: got %0d bad pad words want 0", perrs); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL flush_idle: got %b want 1", idle); else n_pass++;
  endtask

  task automatic test_en_toggle();
    int d0, c0, h0, l0, st, bst, errs;
    bit ok;
    d0 = txn_done; c0 = cap_q.size(); h0 = dout_hold_err; l0 = en_low_cycles;
    en_mode = 1'b1;
    pulse_start(26'h0200000);
    send_words(512, 16'h5000, d0, st, bst);
    wait_txns(d0 + 1, ok);
    en_mode = 1'b0;
    n_checks++; if (!ok) $display("FAIL en_wait: got %0d transfers want 1", txn_done - d0); else n_pass++;
    errs = 0;
    for (int k = 0; k < 512; k++) begin
      logic [15:0] want;
      want = 16'h5000 + 16'(k);
      if (c0 + k >= cap_q.size() || cap_q[c0 + k] !== want) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL en_data: got %0d bad words want 0", errs); else n_pass++;
    n_checks++; if (dout_hold_err != h0) $display("FAIL en_hold: got %0d changes while en=0 want 0", dout_hold_err - h0); else n_pass++;
    n_checks++; if (en_low_cycles == l0) $display("FAIL en_gaps: got %0d en=0 cycles want >0", en_low_cycles - l0); else n_pass++;
  endtask

  task automatic test_busy_delay();
    int d0, c0, a0, r0, hb0, db0, dq0, st, bst, errs;
    logic [25:0] got0, got1;
    bit ok;
    d0 = txn_done; c0 = cap_q.size(); a0 = addr_q.size(); r0 = req_count;
    hb0 = hold_bad; db0 = drop_bad; dq0 = dup_req;
    busy_delay = 20;
    pulse_start(26'h3FFFE00);
    send_words(1024, 16'h6000, d0, st, bst);
    wait_txns(d0 + 2, ok);
    busy_delay = 2;
    n_checks++; if (!ok) $display("FAIL busy_wait: got %0d transfers want 2", txn_done - d0); else n_pass++;
    n_checks++; if (req_count - r0 != 2) $display("FAIL busy_reqs: got %0d want 2", req_count - r0); else n_pass++;
    n_checks++; if (last_req_hi != 21) $display("FAIL busy_req_width: got %0d cycles want 21", last_req_hi); else n_pass++;
    n_checks++; if (hold_bad != hb0) $display("FAIL busy_req_hold: got %0d early drops want 0", hold_bad - hb0); else n_pass++;
    n_checks++; if (drop_bad != db0) $display("FAIL busy_req_drop: got %0d late drops want 0", drop_bad - db0); else n_pass++;
    n_checks++; if (dup_req != dq0) $display("FAIL busy_dup_req: got %0d want 0", dup_req - dq0); else n_pass++;
    got0 = (addr_q.size() > a0) ? addr_q[a0] : 'x;
    got1 = (addr_q.size() > a0 + 1) ? addr_q[a0 + 1] : 'x;
    n_checks++; if (got0 !== 26'h3FFFE00) $display("FAIL busy_addr0: got %h want 3fffe00", got0); else n_pass++;
    n_checks++; if (got1 !== 26'h0000000) $display("FAIL busy_addr_wrap: got %h want 0000000", got1); else n_pass++;
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      logic [15:0] want;
      want = 16'h6000 + 16'(k);
      if (c0 + k >= cap_q.size() || cap_q[c0 + k] !== want) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL busy_data: got %0d bad words want 0", errs); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int st, bst;
    ctl_enable = 1'b0;
    pulse_start(26'h0300000);
    send_words(512, 16'h7000, txn_done, st, bst);
    tick();
    tick();
    n_checks++; if (cp.cpreq !== 1'b1) $display("FAIL mid_cpreq: got %b want 1", cp.cpreq); else n_pass++;
    n_checks++; if (cp.cpsel !== 1'b1) $display("FAIL mid_cpsel: got %b want 1", cp.cpsel); else n_pass++;
    n_checks++; if (cp.cpaddr !== 26'h0300000) $display("FAIL mid_cpaddr: got %h want 0300000", cp.cpaddr); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else n_pass++;
    send_words(50, 16'h7800, txn_done, st, bst);
    reset = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mrst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL mrst_idle: got %b want 1", idle); else n_pass++;
    n_checks++; if (cp.cpsel !== 1'b0) $display("FAIL mrst_cpsel: got %b want 0", cp.cpsel); else n_pass++;
    n_checks++; if (cp.cpreq !== 1'b0) $display("FAIL mrst_cpreq: got %b want 0", cp.cpreq); else n_pass++;
    n_checks++; if (cp.cpaddr !== 26'h0) $display("FAIL mrst_cpaddr: got %h want 0", cp.cpaddr); else n_pass++;
    n_checks++; if (cp.cpdin !== 16'h0) $display("FAIL mrst_cpdin: got %h want 0", cp.cpdin); else n_pass++;
    reset = 1'b0;
    ctl_enable = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_wr = 1'b0; flush = 1'b0;
    base_addr = 26'h0; in_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_en_toggle();
    test_busy_delay();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sdram_cp_feeder.md
Name: sdram_cp_feeder

Overview:
- Source side of the SDRAM controller's page-copy port (cpsel/cpaddr/cpdin/cprd/cpreq/cpbusy).
- Accepts a 16-bit word stream from the loader (ioctl/HPS download path) into a ping-pong buffer of two 512-word banks.
- Hands each full bank to the controller as one 512-word row write, and supplies cpdin in lock-step with cprd.
- Lets ROM downloads proceed while the controller writes the previous bank.

Parameters:
- CP_WORDS, 512: words per copy transaction. Fixed by the controller; any other value is unsupported.
- PAD_VALUE, 16'h0000: fill word written into the unused tail of a flushed partial bank.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- reset  in  1  synchronous, active-high reset.
- en  in  1  mirror of the controller's SDRAM_EN; all copy-side counting advances only when en=1.
- start  in  1  pulse: latch base_addr, clear the stream position.
- base_addr  in  26  word address [26:1]. Bits [9:1] must be 0 (1 KB aligned).
- in_wr  in  1  input word strobe; accepted only when in_ready=1.
- in_data  in  16  input word.
- in_ready  out  1  buffer bank available for filling.
- flush  in  1  pulse: pad the current partial bank and hand it off.
- idle  out  1  both banks empty, no transfer in flight, no padding in progress.
- cpsel  out  1  copy target select.
- cpaddr  out  26  word address [26:1] of the transaction.
- cpdin  out  16  copy data.
- cpreq  out  1  copy request; the controller acts on its rising edge.
- cprd  in  1  controller copy-active strobe.
- cpbusy  in  1  controller copy-busy flag.

Behaviour:
- Reset values: in_ready=1, idle=1, cpsel=0, cpreq=0, cpaddr=0, cpdin=0. Fill and drain bank pointers=0, full[1:0]=0, fill count=0, next address=0.
- Reset mid-transfer: the feeder returns to reset state immediately. The controller's in-flight copy writes undefined data; the loader must not reset while cpbusy=1.
- start: next_addr<=base_addr, fill count<=0. Ignored unless idle=1.
- Fill side:
  - in_ready = ~full[fill_bank] & ~padding.
  - An accepted word is written to RAM[fill_bank][cnt], then cnt++.
  - On the write with cnt=511: full[fill_bank]<=1, bank_addr[fill_bank]<=next_addr, next_addr[26:10]++, fill_bank toggles, cnt<=0.
- Flush:
  - If cnt=0: no action.
  - Otherwise, padding=1 and PAD_VALUE is written one word per clock until cnt wraps. Handoff is then identical to a normal bank completion.
  - flush during padding is ignored.
- Drain FSM:
  - D_IDLE: when full[drain_bank]=1, set cpaddr<=bank_addr[drain_bank], cpsel<=1, rd_ptr<=0, phase<=0, and go to D_REQ.
  - D_REQ: cpreq=1, held until cpbusy=1 is seen, then cpreq<=0 and go to D_XFER. cpreq must be low for at least 1 cycle before each assertion.
  - D_XFER: cpdin timing is defined below. When cpbusy falls: full[drain_bank]<=0, drain_bank toggles, go to D_IDLE.
  - cpsel=1 in D_REQ and D_XFER only.
- cpdin timing, counted on en=1 cycles while cprd=1:
  - Cycle 1 (activate gap) carries don't-care data.
  - Cycle j (j=2..513) must present word j-2 on cpdin.
  - RAM read is registered, so the read address is issued one en-cycle ahead; the first read is issued at cprd cycle 1.
  - en=0 freezes the pointer and holds cpdin.
- Simultaneous events: a fill completion and a drain completion in the same cycle update independent full bits, and both take effect. in_wr together with flush: the word is accepted first and counts toward the pad boundary.
- Ordering: banks drain strictly in fill order. next_addr increments by 512 words per bank and wraps at 2^26 words.
- idle = ~|full & state==D_IDLE & ~padding.

Decomposition:
- Package sdram_cp_pkg holds:
  - CP_WORDS=512
  - CP_LEAD=2 (cprd cycles before the first data word)
  - the drain-state enum {D_IDLE, D_REQ, D_XFER}
- Sub-module cp_dpram: 1024x16 simple dual-port RAM with registered read. Address = {bank, index[8:0]}.

Test Plan:
- Fill 512 words of value 16'h1000+i with base_addr=26'h0040000, using a controller model -> one cpreq, cpaddr=26'h0040000, and the model captures word k=16'h1000+k for k=0..511.
- Stream 1536 words back-to-back with in_wr always high -> in_ready drops only when both banks are full; three transactions go out at 0x0040000, 0x0040200, 0x0040400 in order, with no lost or duplicated words.
- Write 100 words, then flush -> words 0..99 correct, words 100..511 = PAD_VALUE, idle=1 afterwards.
- Toggle en at 50% during cprd -> the captured sequence is still exact; cpdin holds whenever en=0.
- Delay cpbusy by 20 cycles after cpreq -> cpreq holds high throughout and drops the cycle after cpbusy=1, with no second request.
- Assert reset while filling bank 1 with bank 0 full -> all outputs return to reset values and idle=1 the next cycle.
